dkong_wav_fetch: RTL



---
 rtl/dkong_snd_pkg.sv | 15 +
 rtl/dkong_wav_fade.sv | 73 +++++++
 rtl/dkong_wav_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dkong_snd_pkg.sv
// Shared constants and types for the Donkey Kong wave-sound path.
// The sample period is the player's clocks-per-sample at the system clock rate.
package dkong_snd_pkg;

    localparam int         ADDR_W        = 19;
    localparam logic [7:0] MID_LEVEL     = 8'h80;
    localparam int         SAMPLE_PERIOD = 2228;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RETRY
    } fetch_state_e;

endpackage

// File: rtl/dkong_wav_fade.sv
// Audio output register: loads each newly fetched sample and, once the address
// has stayed put long enough, ramps the level one LSB at a time to midscale.
module dkong_wav_fade #(
    parameter int         HOLD_CNT  = 2 * dkong_snd_pkg::SAMPLE_PERIOD,
    parameter int         FADE_DIV  = 64,
    parameter logic [7:0] MID_LEVEL = dkong_snd_pkg::MID_LEVEL
) (
    input  logic       I_CLK,
    input  logic       I_RSTn,
    input  logic       sample_stb,
    input  logic [7:0] sample,
    input  logic       addr_chg,
    output logic [7:0] wav
);

    localparam int HOLD_W = $clog2(HOLD_CNT + 1);
    localparam int DIV_W  = $clog2(FADE_DIV + 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [DIV_W-1:0]  div_reg,  div_next;
    logic [7:0]        wav_reg,  wav_next;
    logic              fade_active;

    // Fade mode is simply the saturated hold counter.
    assign fade_active = (hold_reg == HOLD_W'(HOLD_CNT));
    assign wav         = wav_reg;

    always_comb begin
        hold_next = hold_reg;
        div_next  = div_reg;
        wav_next  = wav_reg;
        if (sample_stb) begin
            // A new byte always beats a fade step landing on the same edge.
            wav_next  = sample;
            hold_next = '0;
            div_next  = '0;
        end else begin
            if (addr_chg) begin
                hold_next = '0;
            end else if (!fade_active) begin
                hold_next = hold_reg + 1'b1;
            end

            if (fade_active) begin
                if (div_reg == DIV_W'(FADE_DIV - 1)) begin
                    div_next = '0;
                    if (wav_reg < MID_LEVEL) begin
                        wav_next = wav_reg + 8'd1;
                    end else if (wav_reg > MID_LEVEL) begin
                        wav_next = wav_reg - 8'd1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end else begin
                div_next = '0;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            hold_reg <= '0;
            div_reg  <= '0;
            wav_reg  <= MID_LEVEL;
        end else begin
            hold_reg <= hold_next;
            div_reg  <= div_next;
            wav_reg  <= wav_next;
        end
    end

endmodule

// File: rtl/dkong_wav_fetch.sv
// Wave-sound sample ROM server: fetches the player's addressed byte from shared
// memory over req/ack (with timeout retry) and drives the faded audio level.
module dkong_wav_fetch #(
    parameter int         ADDR_W    = dkong_snd_pkg::ADDR_W,
    parameter int         TIMEOUT   = 255,
    parameter int         HOLD_CNT  = 2 * dkong_snd_pkg::SAMPLE_PERIOD,
    parameter int         FADE_DIV  = 64,
    parameter logic [7:0] MID_LEVEL = dkong_snd_pkg::MID_LEVEL
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic [ADDR_W-1:0] I_ROM_AB,
    output logic [7:0]        O_ROM_DB,
    output logic              O_ROM_VLD,
    output logic              O_MEM_REQ,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    input  logic              I_MEM_ACK,
    input  logic [7:0]        I_MEM_DATA,
    output logic [7:0]        O_WAV,
    output logic              O_TMO
);

    import dkong_snd_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] addr_last_reg, addr_last_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_req_reg, mem_req_next;
    logic [7:0]        rom_db_reg, rom_db_next;
    logic              rom_vld_reg, rom_vld_next;
    logic              tmo_reg, tmo_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [ADDR_W-1:0] ab_prev_reg;
    logic              vld_d_reg;
    logic              sample_stb;
    logic              addr_chg;

    always_comb begin
        state_next     = state_reg;
        addr_last_next = addr_last_reg;
        mem_addr_next  = mem_addr_reg;
        mem_req_next   = mem_req_reg;
        rom_db_next    = rom_db_reg;
        rom_vld_next   = rom_vld_reg;
        tmo_next       = 1'b0;
        tmo_cnt_next   = tmo_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (I_ROM_AB != addr_last_reg) begin
                    addr_last_next = I_ROM_AB;
                    mem_addr_next  = I_ROM_AB;
                    mem_req_next   = 1'b1;
                    rom_vld_next   = 1'b0;
                    tmo_cnt_next   = '0;
                    state_next     = REQ;
                end
            end
            REQ: begin
                if (I_MEM_ACK) begin
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                    // Stale data for an address the player already left is dropped;
                    // IDLE sees the mismatch next cycle and refetches.
                    if (I_ROM_AB == addr_last_reg) begin
                        rom_db_next  = I_MEM_DATA;
                        rom_vld_next = 1'b1;
                    end
                end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
                    mem_req_next = 1'b0;
                    tmo_next     = 1'b1;
                    state_next   = RETRY;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            RETRY: begin
                mem_req_next = 1'b1;
                tmo_cnt_next = '0;
                state_next   = REQ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_reg     <= IDLE;
            addr_last_reg <= '1;
            mem_addr_reg  <= '0;
            mem_req_reg   <= 1'b0;
            rom_db_reg    <= '0;
            rom_vld_reg   <= 1'b0;
            tmo_reg       <= 1'b0;
            tmo_cnt_reg   <= '0;
            ab_prev_reg   <= '1;
            vld_d_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_last_reg <= addr_last_next;
            mem_addr_reg  <= mem_addr_next;
            mem_req_reg   <= mem_req_next;
            rom_db_reg    <= rom_db_next;
            rom_vld_reg   <= rom_vld_next;
            tmo_reg       <= tmo_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            ab_prev_reg   <= I_ROM_AB;
            vld_d_reg     <= rom_vld_reg;
        end
    end

    assign sample_stb = rom_vld_reg & ~vld_d_reg;
    assign addr_chg   = (I_ROM_AB != ab_prev_reg);

    dkong_wav_fade #(
        .HOLD_CNT  (HOLD_CNT),
        .FADE_DIV  (FADE_DIV),
        .MID_LEVEL (MID_LEVEL)
    ) u_fade (
        .I_CLK      (I_CLK),
        .I_RSTn     (I_RSTn),
        .sample_stb (sample_stb),
        .sample     (rom_db_reg),
        .addr_chg   (addr_chg),
        .wav        (O_WAV)
    );

    assign O_ROM_DB   = rom_db_reg;
    assign O_ROM_VLD  = rom_vld_reg;
    assign O_MEM_REQ  = mem_req_reg;
    assign O_MEM_ADDR = mem_addr_reg;
    assign O_TMO      = tmo_reg;

endmodule
